// File: rtl/cnt_lock_ctrl.sv
// Multi-channel debounced counter lock: turns per-channel enable/inhibit
// requests into registered count-enables with toggle or follow behaviour.
module cnt_lock_ctrl #(
    parameter int N_CH    = 4,
    parameter int DEB_CYC = 4,
    parameter bit INIT_EN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] enb_lock,
    input  logic [N_CH-1:0] dis_lock,
    input  logic            mode,
    input  logic            clr_all,
    output logic [N_CH-1:0] enb_cnt,
    output logic [N_CH-1:0] tgl_pulse,
    output logic            any_en
);

    localparam int              CW   = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEB_CYC - 1);

    logic [N_CH-1:0] req_q;
    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] stable_next;
    logic [N_CH-1:0] accept;
    logic [N_CH-1:0] enb_next;
    logic [CW-1:0]   cnt      [N_CH];
    logic [CW-1:0]   cnt_next [N_CH];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        stable_next = stable;
        accept      = '0;
        enb_next    = enb_cnt;
        for (int i = 0; i < N_CH; i++) begin
            cnt_next[i] = cnt[i];
            if (req_q[i] == stable[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == LAST) begin
                accept[i]      = 1'b1;
                stable_next[i] = req_q[i];
                cnt_next[i]    = '0;
            end else begin
                cnt_next[i] = cnt[i] + CW'(1);
            end

            // Toggle mode reacts only to a rising acceptance; follow mode copies it.
            if (accept[i]) begin
                if (mode)
                    enb_next[i] = req_q[i];
                else if (req_q[i])
                    enb_next[i] = ~enb_cnt[i];
            end
        end
        // Clear wins over acceptance, but debounce state above still advances.
        if (clr_all)
            enb_next = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            stable    <= '0;
            enb_cnt   <= {N_CH{INIT_EN}};
            tgl_pulse <= '0;
            any_en    <= INIT_EN;
            // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is cheap and required.
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= '0;
        end else begin
            req_q     <= enb_lock & ~dis_lock;
            stable    <= stable_next;
            enb_cnt   <= enb_next;
            tgl_pulse <= enb_next ^ enb_cnt;
            any_en    <= |enb_next;
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= cnt_next[i];
        end
    end

endmodule

// File: tb/tb_cnt_lock_ctrl.sv
// Bench for cnt_lock_ctrl: two instances (DEB_CYC=4/INIT_EN=0 and DEB_CYC=1/INIT_EN=1)
// compared every cycle against a run-length reference model, plus directed literal checks.
module tb_cnt_lock_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] enb_lock;
    logic [N-1:0] dis_lock;
    logic         mode;
    logic         clr_all;
    logic [N-1:0] enb_cnt0, tgl0, enb_cnt1, tgl1;
    logic         any0, any1;

    always #5 clk = ~clk;

    cnt_lock_ctrl #(.N_CH(N), .DEB_CYC(4), .INIT_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .enb_lock(enb_lock), .dis_lock(dis_lock),
        .mode(mode), .clr_all(clr_all),
        .enb_cnt(enb_cnt0), .tgl_pulse(tgl0), .any_en(any0)
    );

    cnt_lock_ctrl #(.N_CH(N), .DEB_CYC(1), .INIT_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .enb_lock(enb_lock), .dis_lock(dis_lock),
        .mode(mode), .clr_all(clr_all),
        .enb_cnt(enb_cnt1), .tgl_pulse(tgl1), .any_en(any1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a request is accepted once the captured request has
    // disagreed with the accepted level for DEB_CYC consecutive edges.
    int           deb_v [2] = '{4, 1};
    logic         init_v[2] = '{1'b0, 1'b1};
    logic [N-1:0] m_rq [2];
    logic [N-1:0] m_st [2];
    logic [N-1:0] m_en [2];
    logic [N-1:0] m_pl [2];
    logic         m_any[2];
    int           m_run[2][N];

    always @(posedge clk) begin
        logic [N-1:0] nv;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_rq[d]  = '0;
                m_st[d]  = '0;
                m_en[d]  = {N{init_v[d]}};
                m_pl[d]  = '0;
                m_any[d] = init_v[d];
                for (int i = 0; i < N; i++) m_run[d][i] = 0;
            end else begin
                nv = m_en[d];
                for (int i = 0; i < N; i++) begin
                    if (m_rq[d][i] != m_st[d][i]) begin
                        m_run[d][i]++;
                        if (m_run[d][i] == deb_v[d]) begin
                            m_run[d][i] = 0;
                            m_st[d][i]  = m_rq[d][i];
                            if (mode)
                                nv[i] = m_rq[d][i];
                            else if (m_rq[d][i])
                                nv[i] = !m_en[d][i];
                        end
                    end else begin
                        m_run[d][i] = 0;
                    end
                end
                if (clr_all) nv = '0;
                m_pl[d]  = nv ^ m_en[d];
                m_en[d]  = nv;
                m_any[d] = |nv;
                m_rq[d]  = enb_lock & ~dis_lock;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("enb_cnt0", 32'(enb_cnt0), 32'(m_en[0]));
            check("tgl0",     32'(tgl0),     32'(m_pl[0]));
            check("any0",     32'(any0),     32'(m_any[0]));
            check("enb_cnt1", 32'(enb_cnt1), 32'(m_en[1]));
            check("tgl1",     32'(tgl1),     32'(m_pl[1]));
            check("any1",     32'(any1),     32'(m_any[1]));
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enb_lock = '0; dis_lock = '0; mode = 1'b0; clr_all = 1'b0;
        wait_neg(2);
        check("reset enb0", 32'(enb_cnt0), 32'h0);
        check("reset any0", 32'(any0),     32'h0);
        check("reset tgl0", 32'(tgl0),     32'h0);
        check("reset enb1", 32'(enb_cnt1), 32'hF);
        check("reset any1", 32'(any1),     32'h1);
        chk_en = 1'b1;
        rst = 1'b0;
        wait_neg(3);

        // Toggle mode press on ch0: captured at edge k, accepted at k+4.
        enb_lock = 4'b0001;
        wait_neg(4);
        check("press k+3 enb0", 32'(enb_cnt0), 32'h0);
        wait_neg(1);
        check("press k+4 enb0", 32'(enb_cnt0), 32'h1);
        check("press k+4 tgl0", 32'(tgl0),     32'h1);
        wait_neg(1);
        check("press k+5 tgl0", 32'(tgl0),     32'h0);
        wait_neg(4);
        check("held enb0",      32'(enb_cnt0), 32'h1);
        enb_lock = 4'b0000;
        wait_neg(6);
        check("release enb0",   32'(enb_cnt0), 32'h1);
        enb_lock = 4'b0001;
        wait_neg(8);
        check("repress enb0",   32'(enb_cnt0), 32'h0);
        enb_lock = 4'b0000;
        wait_neg(6);

        // Three-cycle glitch on ch1, then inhibited request.
        enb_lock = 4'b0010;
        wait_neg(3);
        enb_lock = 4'b0000;
        wait_neg(6);
        check("glitch enb0",    32'(enb_cnt0), 32'h0);
        enb_lock = 4'b0010; dis_lock = 4'b0010;
        wait_neg(8);
        check("inhibit enb0",   32'(enb_cnt0), 32'h0);
        enb_lock = 4'b0000; dis_lock = 4'b0000;
        wait_neg(6);

        // clr_all while ch0 enabled and request still held.
        enb_lock = 4'b0001;
        wait_neg(6);
        check("pre-clr enb0",   32'(enb_cnt0), 32'h1);
        clr_all = 1'b1;
        wait_neg(1);
        clr_all = 1'b0;
        check("clr enb0",       32'(enb_cnt0), 32'h0);
        check("clr tgl0",       32'(tgl0),     32'h1);
        wait_neg(6);
        check("post-clr enb0",  32'(enb_cnt0), 32'h0);

        // Follow mode on ch2.
        mode = 1'b1;
        enb_lock = 4'b0101;
        wait_neg(5);
        check("follow on enb0", 32'(enb_cnt0), 32'h4);
        wait_neg(1);
        enb_lock = 4'b0001;
        wait_neg(5);
        check("follow off enb0", 32'(enb_cnt0), 32'h0);
        wait_neg(2);

        // Randomised run against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) enb_lock[i] = ~enb_lock[i];
                if ($urandom_range(0, 9) == 0) dis_lock[i] = ~dis_lock[i];
            end
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            clr_all = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            wait_neg(1);
        end
        rst = 1'b0; clr_all = 1'b0;
        wait_neg(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnt_lock_ctrl.md
Name: cnt_lock_ctrl

Overview:
Multi-channel, debounced successor to the single-channel counter lock.
- Each channel turns an enable/disable request pair into a registered counter-enable (`enb_cnt`).
- Each channel supports toggle or follow mode, per-channel debounce, and a global synchronous clear.
- Sits between the front-panel button synchroniser and the counter/timekeeping blocks. Drives their count-enable inputs.
- Fully synchronous: no derived clocks or edge-triggered logic on data signals.

Parameters:
N_CH, 4, number of independent lock channels (1..16)
DEB_CYC, 4, consecutive cycles a request change must persist before acceptance (1..65535)
INIT_EN, 0, reset value of every enb_cnt bit (0 or 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
enb_lock  in  N_CH  per-channel lock request
dis_lock  in  N_CH  per-channel request inhibit
mode  in  1  0 = toggle mode, 1 = follow mode (global, sampled every cycle)
clr_all  in  1  synchronous clear of all enb_cnt bits
enb_cnt  out  N_CH  registered counter enable per channel
tgl_pulse  out  N_CH  one-cycle pulse when the corresponding enb_cnt changes
any_en  out  1  registered OR of enb_cnt

Behaviour:
Interface:
- One clock (`clk`).
- Reset `rst` is synchronous and active-high.

Reset (`rst`=1 at an edge):
- enb_cnt = {N_CH{INIT_EN}}.
- tgl_pulse = 0.
- any_en = INIT_EN.
- Internal req_q = 0, stable = 0, debounce counters = 0.
- `rst` overrides every other input.
- Reset mid-debounce discards the pending change.

Per-channel request:
- req[i] = enb_lock[i] & ~dis_lock[i].
- req is registered into req_q[i] every edge.

Debounce:
- Counter width is clog2(DEB_CYC+1).
- If req_q[i] == stable[i]: counter <= 0.
- Else if counter == DEB_CYC-1: stable[i] <= req_q[i], counter <= 0 (acceptance).
- Else: counter increments.
- A glitch shorter than DEB_CYC cycles produces no acceptance.
- Latency: request held from edge k (captured into req_q) is accepted at edge k+DEB_CYC.
- With DEB_CYC=1, acceptance occurs one edge after capture.

Output update, on the acceptance edge:
- Toggle mode (mode=0): on a rising acceptance (stable 0→1), enb_cnt[i] inverts. A falling acceptance changes nothing.
- Follow mode (mode=1): enb_cnt[i] <= new stable value on any acceptance.
- Mode change with no acceptance pending does not alter enb_cnt.

clr_all:
- At an edge, all enb_cnt <= 0.
- clr_all has priority over a simultaneous acceptance.
- stable and the debounce counters are still updated normally, so a held request does not re-toggle after clear.

tgl_pulse[i]:
- 1 for exactly the cycle after any edge where enb_cnt[i] changed value, including change by clr_all.
- 0 otherwise.
- A clear of an already-0 bit gives no pulse.

any_en:
- Registered from the next-state enb_cnt, so it is coincident with enb_cnt.

Channel independence:
- Channels are fully independent.
- Simultaneous acceptances on several channels all take effect in the same cycle.

Test Plan:
1. Reset then idle, N_CH=4, INIT_EN=0 -> enb_cnt=4'b0000, any_en=0, tgl_pulse=0.
2. Toggle mode, DEB_CYC=4, enb_lock[0] held high 10 cycles starting before edge k -> enb_cnt[0] 0→1 at edge k+4, tgl_pulse[0] high one cycle, no further change while held; release then re-press -> enb_cnt[0] returns to 0.
3. Glitch: enb_lock[1]=1 for 3 cycles with DEB_CYC=4 -> enb_cnt[1] unchanged, tgl_pulse[1]=0; dis_lock[1]=1 with enb_lock[1]=1 held 8 cycles -> no change.
4. Follow mode, enb_lock[2] high 6 cycles then low -> enb_cnt[2]=1 at capture+4, back to 0 at release capture+4, two tgl_pulse events.
5. clr_all asserted on the same edge as an acceptance on channel 3 while enb_cnt=4'b0101 -> enb_cnt=4'b0000, tgl_pulse=4'b0101, no toggle on ch3 while request held.
6. rst asserted mid-debounce (counter=2) on ch0 with INIT_EN=1 -> enb_cnt=4'b1111 next cycle; pending change lost; request must then persist a full DEB_CYC after capture to be accepted.
